cm0_acg_ctrl: RTL



---
 rtl/cm0_acg_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/cm0_acg_ctrl.sv
// Per-domain clock-gate enable controller: wake handshake with settle delay and
// idle hysteresis per channel, all on the ungated root clock.

module cm0_acg_chan #(
  parameter int WAKE_CYCLES = 1,
  parameter int IDLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic wake,
  output logic gate_en,
  output logic ack,
  output logic gate_nxt
);
  localparam logic [1:0] S_OFF  = 2'd0;
  localparam logic [1:0] S_WAKE = 2'd1;
  localparam logic [1:0] S_ON   = 2'd2;
  localparam logic [1:0] S_IDLE = 2'd3;

  localparam int WL = (WAKE_CYCLES > 0) ? WAKE_CYCLES - 1 : 0;
  localparam int IL = (IDLE_CYCLES > 0) ? IDLE_CYCLES - 1 : 0;
  localparam logic [3:0] WAKE_LD = WL[3:0];
  localparam logic [3:0] IDLE_LD = IL[3:0];

  logic [1:0] st, st_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       ack_nxt;

  always_comb begin
    st_nxt  = st;
    cnt_nxt = cnt;
    case (st)
      S_OFF: if (wake) begin
        if (WAKE_CYCLES > 0) begin
          st_nxt  = S_WAKE;
          cnt_nxt = WAKE_LD;
        end else begin
          st_nxt  = S_ON;
        end
      end
      // Wake is not re-sampled here: a started wake always completes.
      S_WAKE: if (cnt == 4'd0) st_nxt = S_ON;
              else             cnt_nxt = cnt - 4'd1;
      S_ON: if (!wake) begin
        if (IDLE_CYCLES > 0) begin
          st_nxt  = S_IDLE;
          cnt_nxt = IDLE_LD;
        end else begin
          st_nxt  = S_OFF;
        end
      end
      default: begin
        if (wake)              st_nxt  = S_ON;
        else if (cnt == 4'd0)  st_nxt  = S_OFF;
        else                   cnt_nxt = cnt - 4'd1;
      end
    endcase
  end

  assign gate_nxt = (st_nxt != S_OFF);
  assign ack_nxt  = (st_nxt == S_ON) || (st_nxt == S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= S_OFF;
      cnt     <= 4'd0;
      gate_en <= 1'b0;
      ack     <= 1'b0;
    end else begin
      st      <= st_nxt;
      cnt     <= cnt_nxt;
      gate_en <= gate_nxt;
      ack     <= ack_nxt;
    end
  end
endmodule

module cm0_acg_ctrl #(
  parameter int NCH         = 2,
  parameter int ACG         = 1,
  parameter int WAKE_CYCLES = 1,
  parameter int IDLE_CYCLES = 4
) (
  input  logic           CLKIN,
  input  logic           RESET,
  input  logic [NCH-1:0] REQ,
  input  logic [NCH-1:0] BUSY,
  input  logic           DBGFORCE,
  output logic [NCH-1:0] ACK,
  output logic [NCH-1:0] GATE_EN,
  output logic           ANY_ON
);
  if (ACG != 0) begin : g_acg
    logic [NCH-1:0] wake;
    logic [NCH-1:0] gate_nxt;

    assign wake = REQ | BUSY | {NCH{DBGFORCE}};

    cm0_acg_chan #(
      .WAKE_CYCLES(WAKE_CYCLES),
      .IDLE_CYCLES(IDLE_CYCLES)
    ) u_ch [NCH-1:0] (
      .clk     (CLKIN),
      .rst     (RESET),
      .wake    (wake),
      .gate_en (GATE_EN),
      .ack     (ACK),
      .gate_nxt(gate_nxt)
    );

    // Built from next-state enables so it lines up with GATE_EN.
    always_ff @(posedge CLKIN) begin
      if (RESET) ANY_ON <= 1'b0;
      else       ANY_ON <= |gate_nxt;
    end
  end else begin : g_nogate
    wire unused_in = ^{REQ, BUSY, DBGFORCE};

    assign GATE_EN = '1;
    assign ANY_ON  = 1'b1;

    always_ff @(posedge CLKIN) begin
      if (RESET) ACK <= '0;
      else       ACK <= '1;
    end
  end
endmodule
